// File: rtl/vram_frame_sequencer_pkg.sv
// Shared constants and FSM encoding for the VRAM frame sequencer.
// Geometry is fixed at a 128x128 source image addressed as {row, col}.
package vram_frame_sequencer_pkg;

  localparam int IMG_DIM = 128;
  localparam int ADDR_W  = 14;
  localparam int PIX_W   = 10;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 7;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // A hold count of zero means "advance every refresh".
  function automatic logic [CNT_W-1:0] hold_limit(input logic [5:0] hold);
    return (hold == 6'd0) ? 7'd1 : {1'b0, hold};
  endfunction

endpackage

// File: rtl/vram_frame_sequencer_if.sv
// Bus between the sequencer and its bank of 16Kx1 frame BRAMs.
// The master drives the shared address and per-BRAM enables; BRAMs return one bit each.
interface vram_frame_sequencer_if #(parameter int NUM_FRAMES = 10);

  logic [NUM_FRAMES-1:0]                      read_enable;
  logic [vram_frame_sequencer_pkg::ADDR_W-1:0] address;
  logic [1:0]                                 write_enable;
  logic                                       reg_enable;
  logic [NUM_FRAMES-1:0]                      frame_pixel;

  modport master (
    output read_enable, address, write_enable, reg_enable,
    input  frame_pixel
  );

  modport slave (
    input  read_enable, address, write_enable, reg_enable,
    output frame_pixel
  );

endinterface

// File: rtl/vram_frame_sequencer_addr_gen.sv
// Pipeline stage 1: image-window test and BRAM address/enable generation.
// Outputs are registered and launch the BRAM read on the following edge.
module vram_addr_gen
  import vram_frame_sequencer_pkg::*;
#(
  parameter int NUM_FRAMES  = 10,
  parameter int ORIGIN_X    = 192,
  parameter int ORIGIN_Y    = 112,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIX_W-1:0]      pixel_x_i,
  input  logic [PIX_W-1:0]      pixel_y_i,
  input  logic                  video_on_i,
  input  logic [IDX_W-1:0]      frame_index_i,
  output logic [ADDR_W-1:0]     address_o,
  output logic [NUM_FRAMES-1:0] read_enable_o,
  output logic                  in_window_o,
  output logic [IDX_W-1:0]      frame_index_o
);

  localparam int SPAN = IMG_DIM << SCALE_SHIFT;

  logic [31:0] px, py, dx, dy;
  logic        in_x, in_y, win;
  logic [6:0]  col, row;

  assign px   = 32'(pixel_x_i);
  assign py   = 32'(pixel_y_i);
  assign dx   = px - 32'(ORIGIN_X);
  assign dy   = py - 32'(ORIGIN_Y);
  assign in_x = (px >= 32'(ORIGIN_X)) && (px < 32'(ORIGIN_X + SPAN));
  assign in_y = (py >= 32'(ORIGIN_Y)) && (py < 32'(ORIGIN_Y + SPAN));
  assign win  = video_on_i && in_x && in_y;
  assign col  = 7'(dx >> SCALE_SHIFT);
  assign row  = 7'(dy >> SCALE_SHIFT);

  logic [ADDR_W-1:0]     address_q;
  logic [NUM_FRAMES-1:0] read_enable_q;
  logic                  in_window_q;
  logic [IDX_W-1:0]      frame_index_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      address_q     <= '0;
      read_enable_q <= '0;
      in_window_q   <= 1'b0;
      frame_index_q <= '0;
    end else begin
      in_window_q   <= win;
      frame_index_q <= frame_index_i;
      if (win) begin
        address_q     <= {row, col};
        read_enable_q <= NUM_FRAMES'(1) << frame_index_i;
      end else begin
        address_q     <= '0;
        read_enable_q <= '0;
      end
    end
  end

  assign address_o     = address_q;
  assign read_enable_o = read_enable_q;
  assign in_window_o   = in_window_q;
  assign frame_index_o = frame_index_q;

endmodule

// File: rtl/vram_frame_sequencer.sv
// Animation sequencer: steps through NUM_FRAMES frame BRAMs at a refresh-based rate
// and streams the selected frame's pixel with a fixed 3-cycle latency.
module vram_frame_sequencer
  import vram_frame_sequencer_pkg::*;
#(
  parameter int   NUM_FRAMES  = 10,
  parameter int   ORIGIN_X    = 192,
  parameter int   ORIGIN_Y    = 112,
  parameter int   SCALE_SHIFT = 1,
  parameter logic BG_VALUE    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIX_W-1:0]       pixel_x,
  input  logic [PIX_W-1:0]       pixel_y,
  input  logic                   video_on,
  input  logic                   frame_start,
  input  logic                   play,
  input  logic                   stop,
  input  logic                   loop_mode,
  input  logic [5:0]             hold_frames,
  vram_frame_sequencer_if.master bram,
  output logic                   pixel_out,
  output logic                   pixel_valid,
  output logic [IDX_W-1:0]       frame_index,
  output logic                   done,
  output seq_state_e             state_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

  seq_state_e        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              done_q;

  assign cnt_inc = cnt_q + 7'd1;

  // stop has priority over play; in STOP a coincident frame_start is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOP;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (stop) begin
      state_q <= ST_STOP;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_STOP: begin
          if (play) begin
            state_q <= ST_PLAY;
            cnt_q   <= '0;
          end
        end
        ST_PLAY: begin
          if (frame_start) begin
            if (cnt_inc >= hold_limit(hold_frames)) begin
              cnt_q <= '0;
              if (idx_q == LAST_IDX) begin
                if (loop_mode) begin
                  idx_q <= '0;
                end else begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ST_DONE: begin
          if (play) begin
            state_q <= ST_PLAY;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= ST_STOP;
      endcase
    end
  end

  logic [ADDR_W-1:0]     s1_addr;
  logic [NUM_FRAMES-1:0] s1_re;
  logic                  s1_win;
  logic [IDX_W-1:0]      s1_idx;

  vram_addr_gen #(
    .NUM_FRAMES  (NUM_FRAMES),
    .ORIGIN_X    (ORIGIN_X),
    .ORIGIN_Y    (ORIGIN_Y),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .pixel_x_i     (pixel_x),
    .pixel_y_i     (pixel_y),
    .video_on_i    (video_on),
    .frame_index_i (idx_q),
    .address_o     (s1_addr),
    .read_enable_o (s1_re),
    .in_window_o   (s1_win),
    .frame_index_o (s1_idx)
  );

  assign bram.address      = s1_addr;
  assign bram.read_enable  = s1_re;
  assign bram.write_enable = 2'b00;
  assign bram.reg_enable   = 1'b0;

  // pixel_valid qualifies pixel_out in the same cycle; the stream has no backpressure.
  logic             s2_win_q;
  logic [IDX_W-1:0] s2_idx_q;
  logic             pixel_out_q;
  logic             pixel_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_win_q      <= 1'b0;
      s2_idx_q      <= '0;
      pixel_valid_q <= 1'b0;
      pixel_out_q   <= BG_VALUE;
    end else begin
      s2_win_q      <= s1_win;
      s2_idx_q      <= s1_idx;
      pixel_valid_q <= s2_win_q;
      pixel_out_q   <= s2_win_q ? bram.frame_pixel[s2_idx_q] : BG_VALUE;
    end
  end

  assign pixel_out   = pixel_out_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_index = idx_q;
  assign done        = done_q;
  assign state_o     = state_q;

endmodule
